// File: rtl/freq_div_ctrl.sv
// freq_div_ctrl: programmable clock divider with independent HIGH/LOW
// phase lengths. New configurations are double-buffered so that they only
// take effect on a period boundary and never truncate or stretch a phase.
module freq_div_ctrl #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          cfg_valid,
  input  logic [CW-1:0] cfg_high,
  input  logic [CW-1:0] cfg_low,
  output logic          cfg_ready,
  output logic          out,
  output logic          period_done,
  output logic          cfg_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t        state_reg,       state_next;
  logic [CW-1:0] cnt_reg,         cnt_next;
  logic          out_reg,         out_next;
  logic          period_done_reg, period_done_next;
  logic          cfg_err_reg,     cfg_err_next;
  logic [CW-1:0] act_high_reg,    act_high_next;
  logic [CW-1:0] act_low_reg,     act_low_next;
  logic [CW-1:0] pend_high_reg,   pend_high_next;
  logic [CW-1:0] pend_low_reg,    pend_low_next;
  logic          pend_v_reg,      pend_v_next;

  logic accept;
  logic cfg_bad;

  // A handshake completes whenever the pending slot is free.
  assign accept  = cfg_valid && !pend_v_reg;
  assign cfg_bad = (cfg_high == '0) || (cfg_low == '0);

  // State register plus all registered outputs; reset restores divide-by-3.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      out_reg         <= 1'b0;
      period_done_reg <= 1'b0;
      cfg_err_reg     <= 1'b0;
      act_high_reg    <= CW'(1);
      act_low_reg     <= CW'(2);
      pend_high_reg   <= '0;
      pend_low_reg    <= '0;
      pend_v_reg      <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      out_reg         <= out_next;
      period_done_reg <= period_done_next;
      cfg_err_reg     <= cfg_err_next;
      act_high_reg    <= act_high_next;
      act_low_reg     <= act_low_next;
      pend_high_reg   <= pend_high_next;
      pend_low_reg    <= pend_low_next;
      pend_v_reg      <= pend_v_next;
    end
  end

  // Next-state logic: phase sequencing, boundary reload, config intake.
  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    out_next         = out_reg;
    period_done_next = 1'b0;
    cfg_err_next     = 1'b0;
    act_high_next    = act_high_reg;
    act_low_next     = act_low_reg;
    pend_high_next   = pend_high_reg;
    pend_low_next    = pend_low_reg;
    pend_v_next      = pend_v_reg;

    case (state_reg)
      IDLE: begin
        out_next = 1'b0;
        if (en) begin
          state_next = HIGH;
          cnt_next   = CW'(1);
          out_next   = 1'b1;
        end
      end
      HIGH: begin
        if (cnt_reg == act_high_reg) begin
          state_next = LOW;
          cnt_next   = CW'(1);
          out_next   = 1'b0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      LOW: begin
        if (cnt_reg == act_low_reg) begin
          // Period boundary: the only place active lengths may change.
          period_done_next = 1'b1;
          if (pend_v_reg) begin
            act_high_next = pend_high_reg;
            act_low_next  = pend_low_reg;
            pend_v_next   = 1'b0;
          end
          if (en) begin
            state_next = HIGH;
            cnt_next   = CW'(1);
            out_next   = 1'b1;
          end else begin
            state_next = IDLE;
            cnt_next   = '0;
            out_next   = 1'b0;
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        out_next   = 1'b0;
      end
    endcase

    // Intake only happens with the slot empty, so it never races the
    // boundary reload above; a config arriving on a boundary edge waits
    // for the following boundary.
    if (accept) begin
      if (cfg_bad) begin
        cfg_err_next = 1'b1;
      end else if (state_reg == IDLE) begin
        act_high_next = cfg_high;
        act_low_next  = cfg_low;
      end else begin
        pend_high_next = cfg_high;
        pend_low_next  = cfg_low;
        pend_v_next    = 1'b1;
      end
    end
  end

  assign cfg_ready   = !pend_v_reg;
  assign out         = out_reg;
  assign period_done = period_done_reg;
  assign cfg_err     = cfg_err_reg;

endmodule

// File: tb/tb_freq_div_ctrl.sv
// Testbench for freq_div_ctrl: directed scenarios plus random stimulus,
// checked every cycle against a period-position reference model.
module tb_freq_div_ctrl;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [CW-1:0] cfg_high = '0;
  logic [CW-1:0] cfg_low = '0;
  logic          cfg_ready;
  logic          out;
  logic          period_done;
  logic          cfg_err;

  freq_div_ctrl #(.CW(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid),
    .cfg_high(cfg_high), .cfg_low(cfg_low), .cfg_ready(cfg_ready),
    .out(out), .period_done(period_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a running flag and the 0-based cycle position in the
  // current period; out is high while the position is inside the HIGH part.
  int m_h, m_l, m_ph, m_pl, m_pos;
  bit m_pv, m_run, m_out, m_pd, m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_h = 1; m_l = 2; m_ph = 0; m_pl = 0; m_pv = 0;
    m_run = 0; m_pos = 0; m_out = 0; m_pd = 0; m_err = 0;
  endtask

  task automatic model_edge();
    bit acc, bad, was_run;
    was_run = m_run;
    acc = cfg_valid && !m_pv;
    bad = (cfg_high == 0) || (cfg_low == 0);
    m_pd = 0;
    m_err = 0;
    if (!m_run) begin
      if (en) begin m_run = 1; m_pos = 0; end
    end else if (m_pos == m_h + m_l - 1) begin
      m_pd = 1;
      if (m_pv) begin m_h = m_ph; m_l = m_pl; m_pv = 0; end
      if (en) m_pos = 0;
      else m_run = 0;
    end else begin
      m_pos++;
    end
    if (acc) begin
      if (bad) m_err = 1;
      else if (!was_run) begin m_h = int'(cfg_high); m_l = int'(cfg_low); end
      else begin m_ph = int'(cfg_high); m_pl = int'(cfg_low); m_pv = 1; end
    end
    m_out = m_run && (m_pos < m_h);
  endtask

  // One clock: advance the model with the inputs seen at the edge, then
  // compare every output shortly after the edge.
  task automatic cyc();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    #1;
    check("out", out, m_out);
    check("period_done", period_done, m_pd);
    check("cfg_err", cfg_err, m_err);
    check("cfg_ready", cfg_ready, !m_pv);
  endtask

  // Advance until the model is in the requested phase (bounded).
  task automatic wait_phase(input bit want_low);
    bit found;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      if (m_run && ((m_pos >= m_h) == want_low)) begin found = 1; break; end
      cyc();
    end
    check("wait_phase", found, 1);
  endtask

  int hi_cnt, pd_at;

  initial begin
    model_reset();
    rst = 1; en = 1;
    #1;
    check("rst_out", out, 0);
    check("rst_ready", cfg_ready, 1);
    cyc(); cyc();
    rst = 0;

    // Default divide-by-3 pattern after reset release.
    for (int k = 0; k < 9; k++) begin
      cyc();
      check("p3_out", out, (k % 3) == 0);
      check("p3_pd", period_done, (k % 3 == 0) && (k > 0));
    end

    // New 2/1 config mid-LOW; current 1/2 period finishes first.
    wait_phase(1);
    cfg_high = 2; cfg_low = 1; cfg_valid = 1;
    cyc();
    cfg_valid = 0;
    check("pend_busy", cfg_ready, 0);
    for (int k = 0; k < 12; k++) cyc();

    // Zero-length config is rejected with a single-cycle error pulse.
    cfg_high = 0; cfg_low = 3; cfg_valid = 1;
    cyc();
    cfg_valid = 0;
    check("err_pulse", cfg_err, 1);
    check("err_ready", cfg_ready, 1);
    cyc();
    check("err_clear", cfg_err, 0);
    for (int k = 0; k < 6; k++) cyc();

    // en dropped during HIGH: period completes, then idle; re-enable.
    wait_phase(0);
    en = 0;
    for (int k = 0; k < 6; k++) cyc();
    check("idle_out", out, 0);
    en = 1;
    cyc();
    check("restart_out", out, 1);

    // Async reset in LOW with a pending config.
    wait_phase(1);
    cfg_high = 3; cfg_low = 3; cfg_valid = 1;
    cyc();
    cfg_valid = 0;
    wait_phase(1);
    check("pend_before_rst", cfg_ready, 0);
    #2 rst = 1;
    #1;
    check("async_out", out, 0);
    check("async_ready", cfg_ready, 1);
    cyc();
    rst = 0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      check("post_rst_p3", out, (k % 3) == 0);
    end

    // Async reset while out is high.
    wait_phase(0);
    #2 rst = 1;
    #1;
    check("async_high_out", out, 0);
    cyc();
    rst = 0;

    // Maximum 15/15 config loaded from IDLE: 30-cycle period, 15 high.
    en = 0;
    for (int k = 0; k < 10; k++) cyc();
    cfg_high = 15; cfg_low = 15; cfg_valid = 1;
    cyc();
    cfg_valid = 0;
    en = 1;
    hi_cnt = 0; pd_at = -1;
    for (int k = 0; k < 60; k++) begin
      cyc();
      if (out) hi_cnt++;
      if (period_done && pd_at < 0) pd_at = k;
    end
    check("max_high_cycles", hi_cnt, 30);
    check("max_period", pd_at, 30);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      en = ($urandom_range(0, 15) != 0);
      cfg_valid = ($urandom_range(0, 5) == 0);
      cfg_high = CW'($urandom_range(0, 15));
      cfg_low = ($urandom_range(0, 3) == 0) ? CW'($urandom_range(0, 2)) : CW'($urandom_range(0, 15));
      cyc();
    end
    cfg_valid = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
